// File: rtl/mult_stage_if.sv
// Issue/complete handshake bundle for the pipelined multiplier functional unit.
// slave is the multiplier's view; master is the issue/complete environment's view.
interface mult_stage_if #(
   parameter int XLEN = 32,
   parameter int PR_W = 6
);

   logic            issue_valid;
   logic [1:0]      issue_func;
   logic [XLEN-1:0] issue_rs1;
   logic [XLEN-1:0] issue_rs2;
   logic [PR_W-1:0] issue_dest_pr;
   logic            issue_ready;
   logic            fu_finish;
   logic [PR_W-1:0] out_dest_pr;
   logic [XLEN-1:0] out_value;
   logic            c_stall;
   logic            squash;

   modport slave (
      input  issue_valid, issue_func, issue_rs1, issue_rs2, issue_dest_pr,
      input  c_stall, squash,
      output issue_ready, fu_finish, out_dest_pr, out_value
   );

   modport master (
      output issue_valid, issue_func, issue_rs1, issue_rs2, issue_dest_pr,
      output c_stall, squash,
      input  issue_ready, fu_finish, out_dest_pr, out_value
   );

endinterface

// File: rtl/mult_stage.sv
// Pipelined RV32M multiplier: one chunk of the multiplier is folded in per slot, with
// bubble-collapsing back-pressure from the complete stage. Optional MULT_STALL_CNT_EN adds stall_cycles.
module mult_stage #(
   parameter int XLEN   = 32,
   parameter int PR_W   = 6,
   parameter int STAGES = 4
) (
   input  logic         clock,
   input  logic         reset,
   mult_stage_if.slave  fu
`ifdef MULT_STALL_CNT_EN
   ,
   output logic [31:0]  stall_cycles
`endif
);

   localparam int W    = 2 * XLEN;
   localparam int C    = W / STAGES;
   localparam int LAST = STAGES - 1;

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULH   = 2'b01,
      OP_MULHSU = 2'b10,
      OP_MULHU  = 2'b11
   } func_e;

   logic [STAGES-1:0] valid_q;
   func_e             func_q  [STAGES];
   logic [PR_W-1:0]   tag_q   [STAGES];
   logic [W-1:0]      mcand_q [STAGES];
   logic [W-1:0]      mrem_q  [STAGES];
   logic [W-1:0]      sum_q   [STAGES];

   logic [LAST-1:0]   adv;
   logic              issue_ready;
   logic [W-1:0]      mcand_in;
   logic [W-1:0]      mplier_in;

   function automatic logic [W-1:0] chunk_product(input logic [W-1:0] mcand,
                                                  input logic [C-1:0] chunk,
                                                  input int unsigned  sh);
      logic [W-1:0] p;
      p = mcand * {{(W-C){1'b0}}, chunk};
      return p << sh;
   endfunction

   always_comb begin
      mcand_in  = {{XLEN{1'b0}}, fu.issue_rs1};
      mplier_in = {{XLEN{1'b0}}, fu.issue_rs2};
      if (fu.issue_func == OP_MULH || fu.issue_func == OP_MULHSU)
         mcand_in = {{XLEN{fu.issue_rs1[XLEN-1]}}, fu.issue_rs1};
      if (fu.issue_func == OP_MULH)
         mplier_in = {{XLEN{fu.issue_rs2[XLEN-1]}}, fu.issue_rs2};
   end

   // A slot may move forward if any slot downstream of it is empty or the last slot is releasing.
   always_comb begin
      logic chain;
      adv   = '0;
      chain = !valid_q[LAST] || !fu.c_stall;
      for (int i = LAST - 1; i >= 0; i--) begin
         chain  = chain || !valid_q[i+1];
         adv[i] = chain;
      end
      issue_ready = !valid_q[0] || adv[0];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            func_q[i]  <= OP_MUL;
            tag_q[i]   <= '0;
            mcand_q[i] <= '0;
            mrem_q[i]  <= '0;
            sum_q[i]   <= '0;
         end
      end else if (fu.squash) begin
         valid_q <= '0;
      end else begin
         for (int i = 1; i < STAGES; i++) begin
            if (adv[i-1]) begin
               valid_q[i] <= valid_q[i-1];
               // Payload only moves with a real op so the output stays put across bubbles.
               if (valid_q[i-1]) begin
                  func_q[i]  <= func_q[i-1];
                  tag_q[i]   <= tag_q[i-1];
                  mcand_q[i] <= mcand_q[i-1];
                  mrem_q[i]  <= mrem_q[i-1] >> C;
                  sum_q[i]   <= sum_q[i-1] + chunk_product(mcand_q[i-1], mrem_q[i-1][C-1:0], i * C);
               end
            end
         end
         if (issue_ready) begin
            valid_q[0] <= fu.issue_valid;
            if (fu.issue_valid) begin
               func_q[0]  <= func_e'(fu.issue_func);
               tag_q[0]   <= fu.issue_dest_pr;
               mcand_q[0] <= mcand_in;
               mrem_q[0]  <= mplier_in >> C;
               sum_q[0]   <= chunk_product(mcand_in, mplier_in[C-1:0], 0);
            end
         end
      end
   end

   assign fu.issue_ready = issue_ready;
   assign fu.fu_finish   = valid_q[LAST];
   assign fu.out_dest_pr = tag_q[LAST];
   assign fu.out_value   = (func_q[LAST] == OP_MUL) ? sum_q[LAST][XLEN-1:0] : sum_q[LAST][W-1:XLEN];

`ifdef MULT_STALL_CNT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         stall_cycles <= '0;
      else if (valid_q[LAST] && fu.c_stall && stall_cycles != 32'hFFFF_FFFF)
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule
